// File: rtl/bus_arbiter_if.sv
// Signal bundle for the two-master arbiter: both master request/ack ports and the shared bus port.
// The slave modport is the arbiter's view. The master modport is the view of the requesters and the bus slave.
interface bus_arbiter_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                  m0_req_i;
  logic                  m0_we_i;
  logic [ADDR_WIDTH-1:0] m0_addr_i;
  logic [DATA_WIDTH-1:0] m0_wdata_i;
  logic [DATA_WIDTH-1:0] m0_rdata_o;
  logic                  m0_ack_o;

  logic                  m1_req_i;
  logic                  m1_we_i;
  logic [ADDR_WIDTH-1:0] m1_addr_i;
  logic [DATA_WIDTH-1:0] m1_wdata_i;
  logic [DATA_WIDTH-1:0] m1_rdata_o;
  logic                  m1_ack_o;

  logic                  bus_rd_en_o;
  logic                  bus_wr_en_o;
  logic [ADDR_WIDTH-1:0] bus_addr_o;
  logic [DATA_WIDTH-1:0] bus_wdata_o;
  logic [DATA_WIDTH-1:0] bus_rdata_i;
  logic                  bus_ack_i;

  logic [1:0]            grant_o;
  logic                  err_o;

  modport slave (
    input  m0_req_i, m0_we_i, m0_addr_i, m0_wdata_i,
    input  m1_req_i, m1_we_i, m1_addr_i, m1_wdata_i,
    input  bus_rdata_i, bus_ack_i,
    output m0_rdata_o, m0_ack_o, m1_rdata_o, m1_ack_o,
    output bus_rd_en_o, bus_wr_en_o, bus_addr_o, bus_wdata_o,
    output grant_o, err_o
  );

  modport master (
    output m0_req_i, m0_we_i, m0_addr_i, m0_wdata_i,
    output m1_req_i, m1_we_i, m1_addr_i, m1_wdata_i,
    output bus_rdata_i, bus_ack_i,
    input  m0_rdata_o, m0_ack_o, m1_rdata_o, m1_ack_o,
    input  bus_rd_en_o, bus_wr_en_o, bus_addr_o, bus_wdata_o,
    input  grant_o, err_o
  );
endinterface

// File: rtl/bus_arbiter.sv
// Round-robin two-master bus arbiter that allows one outstanding transaction (IDLE -> BUSY -> RESP).
// Define ARB_TIMEOUT_EN to force completion with err_o after TIMEOUT_CYCLES BUSY cycles that get no ack.
module bus_arbiter #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic            clk,
  input  logic            rst,
  bus_arbiter_if.slave    bif
);
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  logic [1:0]            state_q, state_d;
  logic                  last_grant_q, last_grant_d;
  logic [1:0]            grant_q, grant_d;
  logic                  we_q, we_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0] rdata_q [2];
  logic [DATA_WIDTH-1:0] rdata_d [2];
  logic                  err_q, err_d;
  logic                  pick_m1;
  logic                  timeout_hit;

`ifdef ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] tmo_cnt_q, tmo_cnt_d;

  // Cleared while idle so every BUSY entry starts from zero; saturates instead of wrapping.
  always_comb begin
    tmo_cnt_d = tmo_cnt_q;
    if (state_q == ST_IDLE)
      tmo_cnt_d = '0;
    else if (state_q == ST_BUSY && tmo_cnt_q != CNT_W'(TIMEOUT_CYCLES))
      tmo_cnt_d = tmo_cnt_q + CNT_W'(1);
  end

  assign timeout_hit = (state_q == ST_BUSY) && (tmo_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) tmo_cnt_q <= '0;
    else     tmo_cnt_q <= tmo_cnt_d;
  end
`else
  assign timeout_hit = 1'b0;
`endif

  // On a tie, m1 wins only when m0 owned the previous grant.
  assign pick_m1 = bif.m1_req_i & (~bif.m0_req_i | ~last_grant_q);

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    grant_d      = grant_q;
    we_d         = we_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    rdata_d      = rdata_q;
    err_d        = err_q;
    case (state_q)
      ST_IDLE: begin
        if (bif.m0_req_i || bif.m1_req_i) begin
          state_d      = ST_BUSY;
          grant_d      = pick_m1 ? 2'b10 : 2'b01;
          last_grant_d = pick_m1;
          we_d         = pick_m1 ? bif.m1_we_i    : bif.m0_we_i;
          addr_d       = pick_m1 ? bif.m1_addr_i  : bif.m0_addr_i;
          wdata_d      = pick_m1 ? bif.m1_wdata_i : bif.m0_wdata_i;
          err_d        = 1'b0;
        end
      end
      ST_BUSY: begin
        // A real ack beats a timeout that lands in the same cycle.
        if (bif.bus_ack_i || timeout_hit) begin
          state_d             = ST_RESP;
          err_d               = ~bif.bus_ack_i;
          rdata_d[grant_q[1]] = bif.bus_ack_i ? bif.bus_rdata_i : '0;
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
        grant_d = 2'b00;
      end
      default: begin
        state_d = ST_IDLE;
        grant_d = 2'b00;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      last_grant_q <= 1'b1;
      grant_q      <= 2'b00;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      rdata_q[0]   <= '0;
      rdata_q[1]   <= '0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      grant_q      <= grant_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      rdata_q[0]   <= rdata_d[0];
      rdata_q[1]   <= rdata_d[1];
      err_q        <= err_d;
    end
  end

  // Enables decode straight from state so they drop as soon as reset is asserted.
  assign bif.bus_rd_en_o = (state_q == ST_BUSY) & ~we_q;
  assign bif.bus_wr_en_o = (state_q == ST_BUSY) &  we_q;
  assign bif.bus_addr_o  = addr_q;
  assign bif.bus_wdata_o = wdata_q;
  assign bif.grant_o     = grant_q;
  assign bif.m0_ack_o    = (state_q == ST_RESP) & grant_q[0];
  assign bif.m1_ack_o    = (state_q == ST_RESP) & grant_q[1];
  assign bif.m0_rdata_o  = rdata_q[0];
  assign bif.m1_rdata_o  = rdata_q[1];
  assign bif.err_o       = (state_q == ST_RESP) & err_q;
endmodule

// File: doc/bus_arbiter.md
Name: bus_arbiter

Overview:
- Two-master arbiter in front of the shared system bus (bus_interconnect → Memory / led_peripheral).
- Lets the core (master 0) and a second master, e.g. a debug loader or DMA (master 1), share the single bus port.
- Round-robin grant, one outstanding transaction at a time, completion by the slave ack_o.
- Registered request capture; per-master single-cycle ack back to the requester.

Parameters:
ADDR_WIDTH, 32, width of master and bus addresses
DATA_WIDTH, 32, width of read/write data
TIMEOUT_CYCLES, 16, BUSY cycles without bus_ack_i before forced completion (used only with ARB_TIMEOUT_EN)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-high reset
m0_req_i  input  1  master 0 request; held high until m0_ack_o
m0_we_i  input  1  master 0 write (1) / read (0)
m0_addr_i  input  ADDR_WIDTH  master 0 address
m0_wdata_i  input  DATA_WIDTH  master 0 write data
m0_rdata_o  output  DATA_WIDTH  master 0 read data, valid while m0_ack_o=1
m0_ack_o  output  1  master 0 completion pulse
m1_req_i, m1_we_i, m1_addr_i, m1_wdata_i, m1_rdata_o, m1_ack_o  same as m0_*, for master 1
bus_rd_en_o  output  1  bus read enable
bus_wr_en_o  output  1  bus write enable
bus_addr_o  output  ADDR_WIDTH  bus address
bus_wdata_o  output  DATA_WIDTH  bus write data
bus_rdata_i  input  DATA_WIDTH  bus read data, sampled with bus_ack_i
bus_ack_i  input  1  slave completion
grant_o  output  2  one-hot current owner (bit0=m0, bit1=m1); 00 when idle
err_o  output  1  timeout flag, pulses with the failing master's ack

Behaviour:
- Reset (async, immediate): state=IDLE. All outputs 0. last_grant=1, so m0 wins the first tie. Latched request registers 0.
- FSM states: IDLE → BUSY → RESP → IDLE.
- IDLE, any req high:
  - Select the winner: single requester wins. On a tie, the master != last_grant wins.
  - At the clock edge: latch we/addr/wdata, set grant_o one-hot, update last_grant, go to BUSY.
- BUSY:
  - bus_rd_en_o=~we or bus_wr_en_o=we, asserted from the first BUSY cycle.
  - bus_addr_o and bus_wdata_o are driven from the latched registers and stay stable until exit.
  - On bus_ack_i=1 (legal in the first BUSY cycle): latch bus_rdata_i (writes latch too; value is don't-care), go to RESP.
- RESP (exactly 1 cycle):
  - Bus enables 0. Granted master's ack_o=1 with rdata_o = latched data; the other master's rdata_o holds its old value.
  - grant_o keeps its value, then clears to 00 on return to IDLE.
  - No arbitration in RESP. This gives the requester a cycle to drop req.
- Latency: req seen in IDLE at cycle 0 → bus enable at cycle 1 → slave ack at cycle 1+N → ack_o at cycle 2+N. Minimum gap between grants is 3 cycles.
- A held req after ack_o is treated as a new request in the following IDLE cycle.
- req dropped during BUSY: the transaction still completes and ack_o still pulses.
- Inputs changing during BUSY are ignored (the request was latched).
- bus_ack_i in IDLE/RESP is ignored.
- Reset mid-BUSY: bus enables drop asynchronously, no ack is delivered, last_grant returns to 1.
- No counter wrap concerns: the timeout counter saturates and clears on BUSY entry.

Optional Feature:
- Macro ARB_TIMEOUT_EN.
- Defined:
  - A counter increments each BUSY cycle.
  - When it reaches TIMEOUT_CYCLES with no bus_ack_i, go to RESP with rdata latched as 0 and err_o=1 for that RESP cycle.
  - bus_ack_i arriving in the same cycle as the timeout takes precedence (normal completion, err_o=0).
- Not defined: BUSY waits indefinitely for bus_ack_i; err_o is tied 0; TIMEOUT_CYCLES is unused.

Test Plan:
- m0 read 0x0000_0010, slave ack 2 cycles after enable with data 0x1234_5678 → bus_rd_en_o cycles 1-3, m0_ack_o at cycle 4 with m0_rdata_o=0x1234_5678, grant_o=01.
- m1 write 0x8000_0000 data 0x0000_00A5, same-cycle ack → bus_wr_en_o one cycle, bus_wdata_o=0xA5, m1_ack_o next cycle, m0_ack_o stays 0.
- Both req held continuously after reset → grants alternate m0, m1, m0, m1; each transaction 3 cycles apart with immediate ack.
- Assert rst in 2nd BUSY cycle of an m1 read → bus_rd_en_o=0 immediately; no m1_ack_o. Next tie after release grants m0.
- ARB_TIMEOUT_EN, TIMEOUT_CYCLES=16, no ack → after 16 BUSY cycles m0_ack_o=1, err_o=1, m0_rdata_o=0. Without the macro the FSM stays in BUSY for 100+ cycles.
- m0 drops req during BUSY → transaction completes, m0_ack_o pulses once, no second grant.
